// File: rtl/movegen_piece_iter_if.sv
// Board-load bus, iteration control and record stream of movegen_piece_iter.
// slave: the iterator; master: board loader / record consumer side.
interface movegen_piece_iter_if #(
    parameter int DEPTH = 16,
    parameter int CNT_W = $clog2(DEPTH + 1)
);
    logic             in_pos_valid;
    logic             in_pos_sop;
    logic             in_pos_eop;
    logic [3:0]       in_pos_data;
    logic             in_wtp;
    logic             start;
    logic             o_valid;
    logic             o_ready;
    logic [2:0]       o_piece;
    logic [2:0]       o_rank;
    logic [2:0]       o_file;
    logic             o_sop;
    logic             o_eop;
    logic             o_done;
    logic [CNT_W-1:0] o_count;
    logic             busy;
    logic             overflow;

    modport slave (
        input  in_pos_valid, in_pos_sop, in_pos_eop, in_pos_data, in_wtp, start, o_ready,
        output o_valid, o_piece, o_rank, o_file, o_sop, o_eop, o_done, o_count, busy, overflow
    );

    modport master (
        output in_pos_valid, in_pos_sop, in_pos_eop, in_pos_data, in_wtp, start, o_ready,
        input  o_valid, o_piece, o_rank, o_file, o_sop, o_eop, o_done, o_count, busy, overflow
    );
endinterface

// File: rtl/movegen_piece_iter.sv
// Piece iterator: captures per-colour piece lists from the serial board load
// and streams the side-to-play's pieces as {piece, rank, file} records.
// Optional macro MOVEGEN_PIECE_ITER_KINGFIRST_EN: kings live in dedicated
// registers and are always emitted first.
module movegen_piece_iter #(
    parameter int DEPTH = 16,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    movegen_piece_iter_if.slave  bus
);
    localparam int PTR_W = $clog2(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_LOADED, S_ITER} state_t;

    state_t           state_q, state_d;
    logic [5:0]       sq_idx_q, sq_idx_d;
    logic [CNT_W-1:0] cnt_w_q, cnt_w_d, cnt_b_q, cnt_b_d;
    logic             ovf_q, ovf_d;
    logic             side_q, side_d;
    logic [CNT_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic             o_valid_q, o_valid_d;
    logic [2:0]       o_piece_q, o_piece_d, o_rank_q, o_rank_d, o_file_q, o_file_d;
    logic             o_sop_q, o_sop_d, o_eop_q, o_eop_d, o_done_q, o_done_d;
    logic [CNT_W-1:0] o_count_q, o_count_d;
    logic             busy_q, busy_d;
`ifdef MOVEGEN_PIECE_ITER_KINGFIRST_EN
    logic             wking_vld_q, wking_vld_d, bking_vld_q, bking_vld_d;
    logic [8:0]       wking_q, wking_d, bking_q, bking_d;
`endif

    // Stores hold {piece, square index}; unwritten slots are never read.
    logic [8:0]       wmem_q [DEPTH];
    logic [8:0]       bmem_q [DEPTH];
    logic             wr_w, wr_b;
    logic [PTR_W-1:0] wr_ptr;
    logic [8:0]       wr_rec;

    logic             rd_side;
    logic [PTR_W-1:0] rd_idx;
    logic [8:0]       rd_rec;

    logic             beat_sop, take_beat, beat_white;
    logic [2:0]       beat_piece;
    logic [5:0]       beat_idx;
    logic [CNT_W-1:0] cur_cnt;
    logic [CNT_W:0]   tot;
    logic [8:0]       rec;

    // Store read port: entry 0 of the requested side at start, else the iteration pointer.
    always_comb begin
        rd_side = (state_q == S_ITER) ? side_q : bus.in_wtp;
        rd_idx  = (state_q == S_ITER) ? rd_ptr_q[PTR_W-1:0] : '0;
        rd_rec  = rd_side ? wmem_q[rd_idx] : bmem_q[rd_idx];
    end

    // Next-state logic: load beats take priority over start and record handshakes.
    always_comb begin
        state_d   = state_q;
        sq_idx_d  = sq_idx_q;
        cnt_w_d   = cnt_w_q;
        cnt_b_d   = cnt_b_q;
        ovf_d     = ovf_q;
        side_d    = side_q;
        rd_ptr_d  = rd_ptr_q;
        rem_d     = rem_q;
        o_valid_d = o_valid_q;
        o_piece_d = o_piece_q;
        o_rank_d  = o_rank_q;
        o_file_d  = o_file_q;
        o_sop_d   = o_sop_q;
        o_eop_d   = o_eop_q;
        o_done_d  = 1'b0;
        o_count_d = o_count_q;
`ifdef MOVEGEN_PIECE_ITER_KINGFIRST_EN
        wking_vld_d = wking_vld_q;
        bking_vld_d = bking_vld_q;
        wking_d     = wking_q;
        bking_d     = bking_q;
`endif
        wr_w       = 1'b0;
        wr_b       = 1'b0;
        wr_ptr     = '0;
        wr_rec     = '0;
        cur_cnt    = '0;
        tot        = '0;
        rec        = rd_rec;
        beat_sop   = bus.in_pos_valid & bus.in_pos_sop;
        take_beat  = bus.in_pos_valid & (beat_sop | (state_q == S_LOAD));
        beat_idx   = beat_sop ? 6'd0 : sq_idx_q;
        beat_white = bus.in_pos_data[3];
        beat_piece = bus.in_pos_data[2:0];

        if (take_beat) begin
            if (beat_sop) begin
                // A new load aborts any iteration without a done pulse.
                state_d   = S_LOAD;
                cnt_w_d   = '0;
                cnt_b_d   = '0;
                ovf_d     = 1'b0;
                o_valid_d = 1'b0;
                o_sop_d   = 1'b0;
                o_eop_d   = 1'b0;
`ifdef MOVEGEN_PIECE_ITER_KINGFIRST_EN
                wking_vld_d = 1'b0;
                bking_vld_d = 1'b0;
`endif
            end
            sq_idx_d = beat_idx + 6'd1;
            if (beat_piece != 3'd0) begin
`ifdef MOVEGEN_PIECE_ITER_KINGFIRST_EN
                if (beat_piece == 3'd1) begin
                    if (beat_white) begin
                        if (wking_vld_d) ovf_d = 1'b1;
                        wking_vld_d = 1'b1;
                        wking_d     = {beat_piece, beat_idx};
                    end else begin
                        if (bking_vld_d) ovf_d = 1'b1;
                        bking_vld_d = 1'b1;
                        bking_d     = {beat_piece, beat_idx};
                    end
                end else
`endif
                begin
                    cur_cnt = beat_white ? cnt_w_d : cnt_b_d;
                    if (cur_cnt == CNT_W'(DEPTH)) begin
                        ovf_d = 1'b1;
                    end else begin
                        wr_ptr = cur_cnt[PTR_W-1:0];
                        wr_rec = {beat_piece, beat_idx};
                        if (beat_white) begin
                            wr_w    = 1'b1;
                            cnt_w_d = cur_cnt + CNT_W'(1);
                        end else begin
                            wr_b    = 1'b1;
                            cnt_b_d = cur_cnt + CNT_W'(1);
                        end
                    end
                end
            end
            if (bus.in_pos_eop) state_d = S_LOADED;
        end else if (state_q == S_LOADED && bus.start) begin
            side_d = bus.in_wtp;
            tot    = {1'b0, bus.in_wtp ? cnt_w_q : cnt_b_q};
            rd_ptr_d = CNT_W'(1);
`ifdef MOVEGEN_PIECE_ITER_KINGFIRST_EN
            if (bus.in_wtp ? wking_vld_q : bking_vld_q) begin
                tot      = tot + (CNT_W+1)'(1);
                rec      = bus.in_wtp ? wking_q : bking_q;
                rd_ptr_d = '0;
            end
`endif
            o_count_d = CNT_W'(tot);
            if (tot == '0) begin
                o_done_d = 1'b1;
            end else begin
                state_d   = S_ITER;
                o_valid_d = 1'b1;
                o_sop_d   = 1'b1;
                o_eop_d   = (tot == (CNT_W+1)'(1));
                rem_d     = CNT_W'(tot - (CNT_W+1)'(1));
                o_piece_d = rec[8:6];
                o_rank_d  = rec[5:3];
                o_file_d  = rec[2:0];
            end
        end else if (state_q == S_ITER && o_valid_q && bus.o_ready) begin
            if (o_eop_q) begin
                state_d   = S_LOADED;
                o_valid_d = 1'b0;
                o_sop_d   = 1'b0;
                o_eop_d   = 1'b0;
                o_done_d  = 1'b1;
            end else begin
                rd_ptr_d  = rd_ptr_q + CNT_W'(1);
                rem_d     = rem_q - CNT_W'(1);
                o_sop_d   = 1'b0;
                o_eop_d   = (rem_q == CNT_W'(1));
                o_piece_d = rec[8:6];
                o_rank_d  = rec[5:3];
                o_file_d  = rec[2:0];
            end
        end

        busy_d = (state_d == S_LOAD) || (state_d == S_ITER);
    end

    // Control and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            sq_idx_q  <= '0;
            cnt_w_q   <= '0;
            cnt_b_q   <= '0;
            ovf_q     <= 1'b0;
            side_q    <= 1'b0;
            rd_ptr_q  <= '0;
            rem_q     <= '0;
            o_valid_q <= 1'b0;
            o_piece_q <= '0;
            o_rank_q  <= '0;
            o_file_q  <= '0;
            o_sop_q   <= 1'b0;
            o_eop_q   <= 1'b0;
            o_done_q  <= 1'b0;
            o_count_q <= '0;
            busy_q    <= 1'b0;
`ifdef MOVEGEN_PIECE_ITER_KINGFIRST_EN
            wking_vld_q <= 1'b0;
            bking_vld_q <= 1'b0;
            wking_q     <= '0;
            bking_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            sq_idx_q  <= sq_idx_d;
            cnt_w_q   <= cnt_w_d;
            cnt_b_q   <= cnt_b_d;
            ovf_q     <= ovf_d;
            side_q    <= side_d;
            rd_ptr_q  <= rd_ptr_d;
            rem_q     <= rem_d;
            o_valid_q <= o_valid_d;
            o_piece_q <= o_piece_d;
            o_rank_q  <= o_rank_d;
            o_file_q  <= o_file_d;
            o_sop_q   <= o_sop_d;
            o_eop_q   <= o_eop_d;
            o_done_q  <= o_done_d;
            o_count_q <= o_count_d;
            busy_q    <= busy_d;
`ifdef MOVEGEN_PIECE_ITER_KINGFIRST_EN
            wking_vld_q <= wking_vld_d;
            bking_vld_q <= bking_vld_d;
            wking_q     <= wking_d;
            bking_q     <= bking_d;
`endif
        end
    end

    // Piece stores, written in load order.
    always_ff @(posedge clk) begin
        if (wr_w) wmem_q[wr_ptr] <= wr_rec;
        if (wr_b) bmem_q[wr_ptr] <= wr_rec;
    end

    assign bus.o_valid  = o_valid_q;
    assign bus.o_piece  = o_piece_q;
    assign bus.o_rank   = o_rank_q;
    assign bus.o_file   = o_file_q;
    assign bus.o_sop    = o_sop_q;
    assign bus.o_eop    = o_eop_q;
    assign bus.o_done   = o_done_q;
    assign bus.o_count  = o_count_q;
    assign bus.busy     = busy_q;
    assign bus.overflow = ovf_q;
endmodule

// File: tb/tb_movegen_piece_iter.sv
// Directed bench for movegen_piece_iter; three instances (DEPTH 16, 4, 2)
// share one stimulus bus, sel picks the instance being checked.
module tb_movegen_piece_iter;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic       in_pos_valid, in_pos_sop, in_pos_eop, in_wtp, start, o_ready;
    logic [3:0] in_pos_data;

    movegen_piece_iter_if #(.DEPTH(16)) if16 ();
    movegen_piece_iter_if #(.DEPTH(4))  if4 ();
    movegen_piece_iter_if #(.DEPTH(2))  if2 ();

    assign if16.in_pos_valid = in_pos_valid;
    assign if16.in_pos_sop   = in_pos_sop;
    assign if16.in_pos_eop   = in_pos_eop;
    assign if16.in_pos_data  = in_pos_data;
    assign if16.in_wtp       = in_wtp;
    assign if16.start        = start;
    assign if16.o_ready      = o_ready;
    assign if4.in_pos_valid  = in_pos_valid;
    assign if4.in_pos_sop    = in_pos_sop;
    assign if4.in_pos_eop    = in_pos_eop;
    assign if4.in_pos_data   = in_pos_data;
    assign if4.in_wtp        = in_wtp;
    assign if4.start         = start;
    assign if4.o_ready       = o_ready;
    assign if2.in_pos_valid  = in_pos_valid;
    assign if2.in_pos_sop    = in_pos_sop;
    assign if2.in_pos_eop    = in_pos_eop;
    assign if2.in_pos_data   = in_pos_data;
    assign if2.in_wtp        = in_wtp;
    assign if2.start         = start;
    assign if2.o_ready       = o_ready;

    movegen_piece_iter #(.DEPTH(16)) dut16 (.clk(clk), .rst(rst), .bus(if16));
    movegen_piece_iter #(.DEPTH(4))  dut4  (.clk(clk), .rst(rst), .bus(if4));
    movegen_piece_iter #(.DEPTH(2))  dut2  (.clk(clk), .rst(rst), .bus(if2));

    int         sel;
    logic       m_valid, m_sop, m_eop, m_done, m_busy, m_ovf;
    logic [2:0] m_piece, m_rank, m_file;
    logic [5:0] m_count;

    always_comb begin
        case (sel)
            1: begin
                m_valid = if4.o_valid; m_sop = if4.o_sop; m_eop = if4.o_eop; m_done = if4.o_done;
                m_busy = if4.busy; m_ovf = if4.overflow; m_piece = if4.o_piece; m_rank = if4.o_rank;
                m_file = if4.o_file; m_count = 6'(if4.o_count);
            end
            2: begin
                m_valid = if2.o_valid; m_sop = if2.o_sop; m_eop = if2.o_eop; m_done = if2.o_done;
                m_busy = if2.busy; m_ovf = if2.overflow; m_piece = if2.o_piece; m_rank = if2.o_rank;
                m_file = if2.o_file; m_count = 6'(if2.o_count);
            end
            default: begin
                m_valid = if16.o_valid; m_sop = if16.o_sop; m_eop = if16.o_eop; m_done = if16.o_done;
                m_busy = if16.busy; m_ovf = if16.overflow; m_piece = if16.o_piece; m_rank = if16.o_rank;
                m_file = if16.o_file; m_count = 6'(if16.o_count);
            end
        endcase
    end

    int          total = 0;
    int          bad = 0;
    logic [3:0]  board [64];
    logic [10:0] expq [$];
    logic [10:0] gotq [$];
    int          exp_cnt;
    bit          exp_ovf;
    bit          it_done, it_first_valid;
    int          it_done_at;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_board();
        for (int i = 0; i < 64; i++) board[i] = 4'h0;
    endtask

    task automatic put(input int rank, input int file, input bit white, input logic [2:0] piece);
        board[rank * 8 + file] = {white, piece};
    endtask

    // Codes: 1 king, 2 queen, 3 rook, 4 bishop, 5 knight, 6 pawn.
    task automatic set_startpos();
        logic [2:0] back [8];
        back = '{3'd3, 3'd5, 3'd4, 3'd2, 3'd1, 3'd4, 3'd5, 3'd3};
        clear_board();
        for (int f = 0; f < 8; f++) begin
            put(0, f, 1'b1, back[f]);
            put(1, f, 1'b1, 3'd6);
            put(6, f, 1'b0, 3'd6);
            put(7, f, 1'b0, back[f]);
        end
    endtask

    // Reference: expected records {piece, rank, file, sop, eop} for one side.
    task automatic build_exp(input int depth, input bit white);
        logic [8:0] lst [$];
        logic [8:0] krec;
        bit         kv;
        int         cnt;
        expq.delete();
        exp_ovf = 1'b0;
        exp_cnt = 0;
        krec = '0;
        for (int c = 0; c < 2; c++) begin
            cnt = 0;
            kv = 1'b0;
            lst.delete();
            for (int sq = 0; sq < 64; sq++) begin
                logic [3:0] b;
                b = board[sq];
                if (b[2:0] != 3'd0 && int'(b[3]) == c) begin
`ifdef MOVEGEN_PIECE_ITER_KINGFIRST_EN
                    if (b[2:0] == 3'd1) begin
                        if (kv) exp_ovf = 1'b1;
                        kv = 1'b1;
                        krec = {b[2:0], 6'(sq)};
                    end else
`endif
                    if (cnt < depth) begin
                        lst.push_back({b[2:0], 6'(sq)});
                        cnt++;
                    end else begin
                        exp_ovf = 1'b1;
                    end
                end
            end
            if (c == int'(white)) begin
                if (kv) lst.push_front(krec);
                exp_cnt = lst.size();
                for (int i = 0; i < lst.size(); i++)
                    expq.push_back({lst[i], i == 0, i == lst.size() - 1});
            end
        end
    endtask

    // Streams the 64-square board; optionally checks the iterator stays silent.
    task automatic load_board(input bit start_on_eop, input bit chk_quiet);
        for (int i = 0; i < 64; i++) begin
            in_pos_valid = 1'b1;
            in_pos_sop   = (i == 0);
            in_pos_eop   = (i == 63);
            in_pos_data  = board[i];
            start        = start_on_eop && (i == 63);
            tick();
            if (chk_quiet) begin
                total++;
                if (m_valid !== 1'b0 || m_done !== 1'b0) begin
                    bad++;
                    $display("FAIL quiet_during_load beat=%0d valid=%b done=%b want 0 0", i, m_valid, m_done);
                end
            end
            if (i == 10) begin
                total++;
                if (m_busy !== 1'b1) begin
                    bad++;
                    $display("FAIL busy_in_load got=%b want=1", m_busy);
                end
            end
        end
        in_pos_valid = 1'b0;
        in_pos_sop   = 1'b0;
        in_pos_eop   = 1'b0;
        in_pos_data  = 4'h0;
        start        = 1'b0;
    endtask

    // Issues start and collects accepted records until done (bounded).
    // pat 0: ready always high; pat 1: ready cycles 1,0,0,1.
    task automatic run_iter(input bit side, input int pat);
        logic [10:0] rec, held_rec;
        bit          held;
        in_wtp = side;
        start  = 1'b1;
        tick();
        start = 1'b0;
        gotq.delete();
        it_done = 1'b0;
        it_done_at = -1;
        it_first_valid = m_valid;
        held = 1'b0;
        held_rec = '0;
        for (int c = 0; c < 300; c++) begin
            if (m_done) begin
                it_done = 1'b1;
                it_done_at = c;
                break;
            end
            o_ready = (pat == 0) ? 1'b1 : ((c % 4) == 0 || (c % 4) == 3);
            rec = {m_piece, m_rank, m_file, m_sop, m_eop};
            if (held) begin
                total++;
                if (m_valid !== 1'b1 || rec !== held_rec) begin
                    bad++;
                    $display("FAIL hold_stable cyc=%0d got v=%b %h want v=1 %h", c, m_valid, rec, held_rec);
                end
            end
            if (m_valid) begin
                if (o_ready) begin
                    gotq.push_back(rec);
                    held = 1'b0;
                end else begin
                    held = 1'b1;
                    held_rec = rec;
                end
            end
            tick();
        end
        o_ready = 1'b1;
        total++;
        if (!it_done) begin
            bad++;
            $display("FAIL iter_timeout got no done want done within 300 cycles");
        end
    endtask

    task automatic test_reset();
        sel = 0;
        total++;
        if (m_valid !== 1'b0 || m_sop !== 1'b0 || m_eop !== 1'b0 || m_done !== 1'b0) begin
            bad++;
            $display("FAIL reset_flags got %b%b%b%b want 0000", m_valid, m_sop, m_eop, m_done);
        end
        total++;
        if ({m_piece, m_rank, m_file} !== 9'd0 || m_count !== 6'd0) begin
            bad++;
            $display("FAIL reset_record got %h cnt=%0d want 0 0", {m_piece, m_rank, m_file}, m_count);
        end
        total++;
        if (m_busy !== 1'b0 || m_ovf !== 1'b0) begin
            bad++;
            $display("FAIL reset_status busy=%b ovf=%b want 0 0", m_busy, m_ovf);
        end
    endtask

    task automatic test_start_ignored();
        sel = 0;
        in_wtp = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        total++;
        if (m_valid !== 1'b0 || m_done !== 1'b0 || m_busy !== 1'b0) begin
            bad++;
            $display("FAIL start_in_idle v=%b d=%b busy=%b want 0 0 0", m_valid, m_done, m_busy);
        end
        set_startpos();
        load_board(1'b1, 1'b0);
        total++;
        if (m_valid !== 1'b0 || m_done !== 1'b0) begin
            bad++;
            $display("FAIL start_on_eop v=%b d=%b want 0 0", m_valid, m_done);
        end
    endtask

    task automatic test_startpos();
        sel = 0;
        set_startpos();
        load_board(1'b0, 1'b0);
        build_exp(16, 1'b1);
        run_iter(1'b1, 0);
        total++;
        if (gotq.size() != expq.size()) begin
            bad++;
            $display("FAIL startpos_len got=%0d want=%0d", gotq.size(), expq.size());
        end
        for (int i = 0; i < gotq.size() && i < expq.size(); i++) begin
            total++;
            if (gotq[i] !== expq[i]) begin
                bad++;
                $display("FAIL startpos_rec %0d got=%h want=%h", i, gotq[i], expq[i]);
            end
        end
        if (gotq.size() == 16) begin
            total++;
`ifdef MOVEGEN_PIECE_ITER_KINGFIRST_EN
            if (gotq[0] !== {3'd1, 3'd0, 3'd4, 1'b1, 1'b0}) begin
`else
            if (gotq[0] !== {3'd3, 3'd0, 3'd0, 1'b1, 1'b0}) begin
`endif
                bad++;
                $display("FAIL startpos_first got=%h", gotq[0]);
            end
            total++;
            if (gotq[15] !== {3'd6, 3'd1, 3'd7, 1'b0, 1'b1}) begin
                bad++;
                $display("FAIL startpos_last got=%h want=%h", gotq[15], {3'd6, 3'd1, 3'd7, 1'b0, 1'b1});
            end
        end
        total++;
        if (it_first_valid !== 1'b1 || it_done_at != 16) begin
            bad++;
            $display("FAIL startpos_timing first_valid=%b done_at=%0d want 1 16", it_first_valid, it_done_at);
        end
        total++;
        if (m_count !== 6'd16 || m_ovf !== 1'b0) begin
            bad++;
            $display("FAIL startpos_count cnt=%0d ovf=%b want 16 0", m_count, m_ovf);
        end
        tick();
        total++;
        if (m_done !== 1'b0 || m_busy !== 1'b0) begin
            bad++;
            $display("FAIL done_pulse done=%b busy=%b want 0 0", m_done, m_busy);
        end
    endtask

    task automatic test_backpressure_and_reissue();
        sel = 0;
        build_exp(16, 1'b1);
        run_iter(1'b1, 1);
        total++;
        if (gotq.size() != 16) begin
            bad++;
            $display("FAIL bp_len got=%0d want=16", gotq.size());
        end
        for (int i = 0; i < gotq.size() && i < expq.size(); i++) begin
            total++;
            if (gotq[i] !== expq[i]) begin
                bad++;
                $display("FAIL bp_rec %0d got=%h want=%h", i, gotq[i], expq[i]);
            end
        end
        build_exp(16, 1'b0);
        run_iter(1'b0, 0);
        total++;
        if (gotq.size() != expq.size() || m_count !== 6'(exp_cnt)) begin
            bad++;
            $display("FAIL black_len got=%0d cnt=%0d want=%0d", gotq.size(), m_count, expq.size());
        end
        for (int i = 0; i < gotq.size() && i < expq.size(); i++) begin
            total++;
            if (gotq[i] !== expq[i]) begin
                bad++;
                $display("FAIL black_rec %0d got=%h want=%h", i, gotq[i], expq[i]);
            end
        end
    endtask

    task automatic test_async_reset();
        sel = 0;
        set_startpos();
        in_pos_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            in_pos_sop  = (i == 0);
            in_pos_data = board[i];
            tick();
        end
        in_pos_valid = 1'b0;
        in_pos_sop = 1'b0;
        #2 rst = 1'b1;
        #1;
        total++;
        if (m_busy !== 1'b0 || m_count !== 6'd0) begin
            bad++;
            $display("FAIL async_reset busy=%b cnt=%0d want 0 0", m_busy, m_count);
        end
        #1 rst = 1'b0;
        tick();
    endtask

    task automatic test_kings_depth2();
        sel = 2;
        clear_board();
        put(0, 4, 1'b1, 3'd1);
        put(7, 4, 1'b0, 3'd1);
        load_board(1'b0, 1'b0);
        run_iter(1'b0, 0);
        total++;
        if (gotq.size() != 1 || gotq[0] !== {3'd1, 3'd7, 3'd4, 1'b1, 1'b1}) begin
            bad++;
            $display("FAIL king_black n=%0d got=%h want=%h", gotq.size(), gotq.size() ? gotq[0] : 11'h0,
                     {3'd1, 3'd7, 3'd4, 1'b1, 1'b1});
        end
        run_iter(1'b1, 0);
        total++;
        if (gotq.size() != 1 || gotq[0] !== {3'd1, 3'd0, 3'd4, 1'b1, 1'b1} || m_count !== 6'd1) begin
            bad++;
            $display("FAIL king_white n=%0d cnt=%0d want 1 1", gotq.size(), m_count);
        end
    endtask

    task automatic test_overflow_depth4();
        sel = 1;
        clear_board();
        for (int f = 0; f < 6; f++) put(1, f, 1'b1, 3'd6);
        load_board(1'b0, 1'b0);
        build_exp(4, 1'b1);
        total++;
        if (m_ovf !== 1'b1) begin
            bad++;
            $display("FAIL overflow_set got=%b want=1", m_ovf);
        end
        run_iter(1'b1, 0);
        total++;
        if (m_count !== 6'd4 || gotq.size() != 4) begin
            bad++;
            $display("FAIL overflow_count cnt=%0d n=%0d want 4 4", m_count, gotq.size());
        end
        for (int i = 0; i < gotq.size() && i < expq.size(); i++) begin
            total++;
            if (gotq[i] !== expq[i]) begin
                bad++;
                $display("FAIL overflow_rec %0d got=%h want=%h", i, gotq[i], expq[i]);
            end
        end
        in_pos_valid = 1'b1;
        in_pos_sop = 1'b1;
        in_pos_data = 4'h0;
        tick();
        in_pos_valid = 1'b0;
        in_pos_sop = 1'b0;
        total++;
        if (m_ovf !== 1'b0) begin
            bad++;
            $display("FAIL overflow_clear got=%b want=0", m_ovf);
        end
    endtask

    task automatic test_empty_side();
        sel = 0;
        clear_board();
        put(0, 4, 1'b1, 3'd1);
        put(1, 3, 1'b1, 3'd6);
        load_board(1'b0, 1'b0);
        run_iter(1'b0, 0);
        total++;
        if (it_done_at != 0 || gotq.size() != 0 || m_count !== 6'd0) begin
            bad++;
            $display("FAIL empty_side done_at=%0d n=%0d cnt=%0d want 0 0 0", it_done_at, gotq.size(), m_count);
        end
        run_iter(1'b1, 0);
        total++;
        if (gotq.size() != 2 || m_count !== 6'd2) begin
            bad++;
            $display("FAIL after_empty n=%0d cnt=%0d want 2 2", gotq.size(), m_count);
        end
    endtask

    task automatic test_abort();
        logic [10:0] first3 [$];
        sel = 0;
        set_startpos();
        load_board(1'b0, 1'b0);
        build_exp(16, 1'b1);
        in_wtp = 1'b1;
        o_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            first3.push_back({m_piece, m_rank, m_file, m_sop, m_eop});
            tick();
        end
        for (int k = 0; k < 3; k++) begin
            total++;
            if (first3[k] !== expq[k]) begin
                bad++;
                $display("FAIL abort_pre %0d got=%h want=%h", k, first3[k], expq[k]);
            end
        end
        clear_board();
        put(3, 3, 1'b1, 3'd2);
        put(5, 5, 1'b1, 3'd5);
        put(6, 0, 1'b0, 3'd6);
        load_board(1'b0, 1'b1);
        build_exp(16, 1'b1);
        run_iter(1'b1, 0);
        total++;
        if (gotq.size() != 2 || expq.size() != 2 || gotq[0] !== {3'd2, 3'd3, 3'd3, 1'b1, 1'b0} ||
            gotq[1] !== {3'd5, 3'd5, 3'd5, 1'b0, 1'b1}) begin
            bad++;
            $display("FAIL abort_new_board n=%0d want 2 records d4 queen, f6 knight", gotq.size());
        end
    endtask

    task automatic test_king_order();
        sel = 0;
        clear_board();
        put(1, 0, 1'b1, 3'd6);
        put(1, 1, 1'b1, 3'd6);
        put(1, 2, 1'b1, 3'd6);
        put(2, 4, 1'b1, 3'd1);
        load_board(1'b0, 1'b0);
        build_exp(16, 1'b1);
        run_iter(1'b1, 0);
        total++;
        if (gotq.size() != 4) begin
            bad++;
            $display("FAIL kord_len got=%0d want=4", gotq.size());
        end else begin
`ifdef MOVEGEN_PIECE_ITER_KINGFIRST_EN
            if (gotq[0] !== {3'd1, 3'd2, 3'd4, 1'b1, 1'b0} || gotq[3] !== {3'd6, 3'd1, 3'd2, 1'b0, 1'b1}) begin
`else
            if (gotq[0] !== {3'd6, 3'd1, 3'd0, 1'b1, 1'b0} || gotq[3] !== {3'd1, 3'd2, 3'd4, 1'b0, 1'b1}) begin
`endif
                bad++;
                $display("FAIL kord_ends got first=%h last=%h", gotq[0], gotq[3]);
            end
        end
        for (int i = 0; i < gotq.size() && i < expq.size(); i++) begin
            total++;
            if (gotq[i] !== expq[i]) begin
                bad++;
                $display("FAIL kord_rec %0d got=%h want=%h", i, gotq[i], expq[i]);
            end
        end
    endtask

    initial begin
        sel = 0;
        rst = 1'b0;
        in_pos_valid = 1'b0;
        in_pos_sop = 1'b0;
        in_pos_eop = 1'b0;
        in_pos_data = 4'h0;
        in_wtp = 1'b0;
        start = 1'b0;
        o_ready = 1'b1;
        #2 rst = 1'b1;
        #10;
        test_reset();
        rst = 1'b0;
        tick();
        test_start_ignored();
        test_startpos();
        test_backpressure_and_reissue();
        test_async_reset();
        test_kings_depth2();
        test_overflow_depth4();
        test_empty_side();
        test_abort();
        test_king_order();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
